// File: rtl/run_stats_ctrl.sv
// End-of-run statistics sequencer: counts cycles and retired instructions from
// run start to halt, lets the pipeline drain, then serially divides to get fixed-point IPC.
module run_stats_ctrl #(
    parameter int CNT_W        = 32,
    parameter int FRAC_W       = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_start,
    input  logic             instr_retire,
    input  logic             halt,
    input  logic             report_ack,
    output logic             stat_control,
    output logic [CNT_W-1:0] number_cycles,
    output logic [CNT_W-1:0] number_instructions,
    output logic [CNT_W-1:0] ipc_q,
    output logic             busy
);
    // state   | meaning
    // IDLE    | waiting for run_start
    // COUNT   | run in progress, counting cycles/instructions
    // DRAIN   | halt seen, still counting while the pipeline empties
    // DIVIDE  | counters frozen, one quotient bit per cycle
    // REPORT  | results valid, waiting for report_ack

    localparam int DIV_STEPS = CNT_W + FRAC_W;
    localparam int DIV_CW    = $clog2(DIV_STEPS + 1);
    localparam int IDX_W     = $clog2(DIV_STEPS);
    localparam int DRN_W     = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [DRN_W-1:0]  DRN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [DIV_CW-1:0] DIV_LOAD = DIV_CW'(DIV_STEPS);
    localparam logic [CNT_W-1:0]  ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DRAIN,
        ST_DIVIDE,
        ST_REPORT
    } state_t;

    state_t state, state_nxt;

    logic [DRN_W-1:0]     drain_cnt;
    logic [DIV_CW-1:0]    div_cnt;
    logic [CNT_W-1:0]     div_rem;
    logic [DIV_STEPS-2:0] div_quo;

    logic                 count_en;
    logic                 clear_cnt;
    logic                 div_start;
    logic                 div_last;
    logic                 dvd_bit;
    logic                 rem_ge;
    logic [DIV_STEPS-1:0] dividend;
    logic [DIV_STEPS-1:0] quo_next;
    logic [IDX_W-1:0]     div_idx;
    logic [CNT_W:0]       rem_shift;
    logic [CNT_W-1:0]     rem_sub;
    logic [CNT_W-1:0]     ipc_final;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run_start) begin
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // a restart in the same cycle as halt keeps the run going
                if (!run_start && halt) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? ST_DIVIDE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRN_W'(1)) begin
                    state_nxt = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_last) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (report_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        count_en  = ((state == ST_COUNT) && !run_start) || (state == ST_DRAIN);
        clear_cnt = run_start && ((state == ST_IDLE) || (state == ST_COUNT));
        div_start = (state != ST_DIVIDE) && (state_nxt == ST_DIVIDE);
        div_last  = (state == ST_DIVIDE) && (div_cnt == DIV_CW'(1));

        // counters are frozen in DIVIDE, so they serve directly as dividend and divisor
        dividend  = {number_instructions, {FRAC_W{1'b0}}};
        div_idx   = IDX_W'(div_cnt - 1'b1);
        dvd_bit   = dividend[div_idx];
        rem_shift = {div_rem, dvd_bit};
        rem_ge    = rem_shift >= {1'b0, number_cycles};
        rem_sub   = rem_shift[CNT_W-1:0] - number_cycles;
        quo_next  = {div_quo, rem_ge};

        if ((number_cycles == '0) || (quo_next[DIV_STEPS-1:CNT_W] != '0)) begin
            ipc_final = ALL_ONES;
        end else begin
            ipc_final = quo_next[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_control        <= 1'b0;
            busy                <= 1'b0;
            number_cycles       <= '0;
            number_instructions <= '0;
            ipc_q               <= '0;
            drain_cnt           <= '0;
            div_cnt             <= '0;
            div_rem             <= '0;
            div_quo             <= '0;
        end else begin
            stat_control <= (state_nxt == ST_REPORT);
            busy         <= (state_nxt != ST_IDLE);

            if (clear_cnt) begin
                number_cycles       <= '0;
                number_instructions <= '0;
                ipc_q               <= '0;
            end else if (count_en) begin
                if (number_cycles != ALL_ONES) begin
                    number_cycles <= number_cycles + 1'b1;
                end
                if (instr_retire && (number_instructions != ALL_ONES)) begin
                    number_instructions <= number_instructions + 1'b1;
                end
            end

            if ((state == ST_COUNT) && (state_nxt == ST_DRAIN)) begin
                drain_cnt <= DRN_LOAD;
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if (div_start) begin
                div_cnt <= DIV_LOAD;
                div_rem <= '0;
                div_quo <= '0;
            end else if (state == ST_DIVIDE) begin
                div_cnt <= div_cnt - 1'b1;
                div_rem <= rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
                div_quo <= quo_next[DIV_STEPS-2:0];
                if (div_last) begin
                    ipc_q <= ipc_final;
                end
            end
        end
    end

endmodule
